// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and defaults for the PWM capture/generator pair
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam int DEF_CNT_W          = 20;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;
  localparam int DEF_FILTER_LEN     = 4;
  localparam int CLK_HZ             = 50_000_000;

endpackage

// File: rtl/pwm_in_cond.sv
// rtl/pwm_in_cond.sv - synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN), edge detect
module pwm_in_cond #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic cur,
  output logic rise_evt,
  output logic fall_evt
);

  logic sync_1;
  logic sync_2;
  logic prev;
  logic level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pwm_in;
      sync_2 <= sync_1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic              filt;
  logic [FCNT_W-1:0] fcnt;

  // Follow the synchronized level only after it has disagreed for FILTER_LEN cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (sync_2 != filt) begin
      if (fcnt == FCNT_W'(FILTER_LEN - 1)) begin
        filt <= sync_2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else begin
      fcnt <= '0;
    end
  end

  assign level = filt;
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN != 0);
  assign level = sync_2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign cur      = level;
  assign rise_evt = level & ~prev;
  assign fall_evt = ~level & prev;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period measurement with stuck-line timeout; filter via PWM_CAPTURE_FILTER_EN
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

  logic             cur;
  logic             rise_evt;
  logic             fall_evt;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_reg;

  pwm_in_cond #(.FILTER_LEN(FILTER_LEN)) u_cond (
    .clk      (CLOCK_50),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .cur      (cur),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  // Saturate rather than wrap in case the timeout is configured at the counter limit.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      high_reg     <= '0;
      high_count   <= '0;
      period_count <= '0;
      meas_valid   <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_evt) begin
            state <= HIGH;
            cnt   <= CNT_W'(1);
            stuck <= 1'b0;
          end
        end
        HIGH: begin
          if (fall_evt) begin
            high_reg <= cnt;
            cnt      <= cnt_inc;
            state    <= LOW;
          end else if (cnt == CNT_TO) begin
            state        <= IDLE;
            cnt          <= '0;
            stuck        <= 1'b1;
            stuck_level  <= cur;
            high_count   <= '0;
            period_count <= '0;
            meas_valid   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOW: begin
          if (rise_evt) begin
            period_count <= cnt;
            high_count   <= high_reg;
            meas_valid   <= 1'b1;
            cnt          <= CNT_W'(1);
            state        <= HIGH;
          end else if (cnt == CNT_TO) begin
            state        <= IDLE;
            cnt          <= '0;
            stuck        <= 1'b1;
            stuck_level  <= cur;
            high_count   <= '0;
            period_count <= '0;
            meas_valid   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture; expectations adapt to PWM_CAPTURE_FILTER_EN
module tb_pwm_capture;

  localparam int CNT_W = 20;
  localparam int TO    = 2000;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int         cyc;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] p;
    logic       st;
    logic       sl;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n0;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO), .FILTER_LEN(4)) dut (
    .CLOCK_50     (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .high_count   (high_count),
    .period_count (period_count),
    .meas_valid   (meas_valid),
    .stuck        (stuck),
    .stuck_level  (stuck_level)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input int h, input int p, input logic st, input logic sl);
    exp_t e;
    e.cyc = c;
    e.h   = CNT_W'(h);
    e.p   = CNT_W'(p);
    e.st  = st;
    e.sl  = sl;
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One period starting with a rise; the rise reports the previous period when exp_v is set.
  task automatic rise_period(input int h, input int p, input bit exp_v, input int eh, input int ep);
    pwm_in = 1'b1;
    if (exp_v) push(cyc + LAT, eh, ep, 1'b0, 1'b0);
    ticks(h);
    pwm_in = 1'b0;
    ticks(p - h);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_high_count"}, int'(high_count), 0);
    chk({tag, "_period_count"}, int'(period_count), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
    chk({tag, "_stuck_level"}, int'(stuck_level), 0);
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cycle %0d: high=%0d period=%0d stuck=%0b",
                 cyc, high_count, period_count, stuck);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("high_count", int'(high_count), int'(mon_e.h));
        chk("period_count", int'(period_count), int'(mon_e.p));
        chk("stuck", int'(stuck), int'(mon_e.st));
        chk("stuck_level", int'(stuck_level), int'(mon_e.sl));
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    ticks(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    ticks(10);

    // 25% duty, first rise silent
    rise_period(250, 1000, 1'b0, 0, 0);
    rise_period(250, 1000, 1'b1, 250, 1000);
    rise_period(250, 1000, 1'b1, 250, 1000);

    // duty step to 70%
    rise_period(700, 1000, 1'b1, 250, 1000);
    rise_period(700, 1000, 1'b1, 700, 1000);

    // 2-cycle glitch 300 cycles into the low phase
    pwm_in = 1'b1;
    push(cyc + LAT, 700, 1000, 1'b0, 1'b0);
    ticks(250);
    pwm_in = 1'b0;
    ticks(300);
    pwm_in = 1'b1;
`ifndef PWM_CAPTURE_FILTER_EN
    push(cyc + LAT, 250, 550, 1'b0, 1'b0);
`endif
    ticks(2);
    pwm_in = 1'b0;
    ticks(448);
`ifdef PWM_CAPTURE_FILTER_EN
    rise_period(250, 1000, 1'b1, 250, 1000);
`else
    rise_period(250, 1000, 1'b1, 2, 450);
`endif
    rise_period(250, 1000, 1'b1, 250, 1000);

    // line stuck high
    pwm_in = 1'b1;
    push(cyc + LAT, 250, 1000, 1'b0, 1'b0);
    push(cyc + LAT + TO, 0, 0, 1'b1, 1'b1);
    ticks(TO + 100);
    chk("stuck_high_flag", int'(stuck), 1);
    pwm_in = 1'b0;
    ticks(20);
    chk("stuck_held_after_fall", int'(stuck), 1);

    // next rise clears stuck silently, then line stuck low
    pwm_in = 1'b1;
    n0 = cyc;
    ticks(LAT + 2);
    chk("stuck_cleared", int'(stuck), 0);
    ticks(250 - LAT - 2);
    pwm_in = 1'b0;
    push(n0 + LAT + TO, 0, 0, 1'b1, 1'b0);
    ticks(TO);
    chk("stuck_low_flag", int'(stuck), 1);
    chk("stuck_low_level", int'(stuck_level), 0);

    // reset mid-HIGH
    pwm_in = 1'b1;
    ticks(100);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    pwm_in = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(10);
    rise_period(250, 1000, 1'b0, 0, 0);
    rise_period(250, 1000, 1'b1, 250, 1000);
    pwm_in = 1'b1;
    push(cyc + LAT, 250, 1000, 1'b0, 1'b0);
    ticks(20);

    for (int i = 0; i < 50 && sb.size() != 0; i++) ticks(1);
    chk("missing_valids", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
